// File: rtl/dcache_req_arbiter.sv
// Shares the dcache request port between two requesters and tracks the single
// outstanding access by tag: replays NACKs, handles kill/drain, retry exhaustion and timeout.
module dcache_req_arbiter #(
   parameter int DATA_W    = 128,
   parameter int ADDR_W    = 40,
   parameter int MAX_RETRY = 7,
   parameter int TIMEOUT   = 255
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic [1:0]             req_valid_i,
   output logic [1:0]             req_ready_o,
   input  logic [1:0][4:0]        req_cmd_i,
   input  logic [1:0][ADDR_W-1:0] req_addr_i,
   input  logic [1:0][3:0]        req_size_i,
   input  logic [1:0][DATA_W-1:0] req_data_i,
   input  logic [1:0][4:0]        req_rd_i,
   input  logic                   kill_i,
   output logic                   dmem_req_valid_o,
   input  logic                   dmem_req_ready_i,
   output logic [4:0]             dmem_req_cmd_o,
   output logic [ADDR_W-1:0]      dmem_req_addr_o,
   output logic [3:0]             dmem_op_type_o,
   output logic [DATA_W-1:0]      dmem_req_data_o,
   output logic [7:0]             dmem_req_tag_o,
   output logic                   dmem_req_kill_o,
   input  logic                   dmem_resp_valid_i,
   input  logic                   dmem_resp_nack_i,
   input  logic [7:0]             dmem_resp_tag_i,
   input  logic [DATA_W-1:0]      dmem_resp_data_i,
   output logic [1:0]             resp_valid_o,
   output logic                   resp_error_o,
   output logic [DATA_W-1:0]      resp_data_o,
   output logic                   busy_o
);
   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]    state;
   logic          rr;
   logic          owner;
   logic          grant;
   logic          accept;
   logic [RW-1:0] retry_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          tag_hit;
   logic          nack_hit;
   logic          data_hit;
   logic          tmo_hit;

   // Round-robin pointer only matters when both requesters contend.
   assign grant  = (req_valid_i == 2'b11) ? rr : req_valid_i[1];
   assign accept = rstn_i && (state == S_IDLE) && (|req_valid_i);

   always_comb begin
      req_ready_o = '0;
      if (accept) req_ready_o[grant] = 1'b1;
   end

   assign tag_hit  = (dmem_resp_tag_i == dmem_req_tag_o);
   assign nack_hit = dmem_resp_nack_i && tag_hit;
   assign data_hit = dmem_resp_valid_i && tag_hit && !dmem_resp_nack_i;
   assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT));

   assign dmem_req_valid_o = (state == S_ISSUE);
   // A kill in ISSUE only reaches the cache if the request was taken that cycle.
   assign dmem_req_kill_o  = rstn_i && kill_i &&
                             (((state == S_ISSUE) && dmem_req_ready_i) || (state == S_WAIT));
   assign busy_o           = (state != S_IDLE);

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state           <= S_IDLE;
         rr              <= 1'b0;
         owner           <= 1'b0;
         retry_cnt       <= '0;
         tmo_cnt         <= '0;
         dmem_req_cmd_o  <= '0;
         dmem_req_addr_o <= '0;
         dmem_op_type_o  <= '0;
         dmem_req_data_o <= '0;
         dmem_req_tag_o  <= '0;
         resp_valid_o    <= '0;
         resp_error_o    <= 1'b0;
         resp_data_o     <= '0;
      end else begin
         resp_valid_o <= '0;
         resp_error_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  owner           <= grant;
                  rr              <= ~grant;
                  dmem_req_cmd_o  <= req_cmd_i[grant];
                  dmem_req_addr_o <= req_addr_i[grant];
                  dmem_op_type_o  <= req_size_i[grant];
                  dmem_req_data_o <= req_data_i[grant];
                  dmem_req_tag_o  <= {1'b0, grant, req_rd_i[grant], 1'b0};
                  retry_cnt       <= '0;
                  state           <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (kill_i) begin
                  state <= S_IDLE;
               end else if (dmem_req_ready_i) begin
                  tmo_cnt <= '0;
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (kill_i) begin
                  tmo_cnt <= '0;
                  state   <= (nack_hit || data_hit) ? S_IDLE : S_DRAIN;
               end else if (nack_hit) begin
                  if (retry_cnt == RW'(MAX_RETRY)) begin
                     resp_valid_o[owner] <= 1'b1;
                     resp_error_o        <= 1'b1;
                     state               <= S_IDLE;
                  end else begin
                     retry_cnt <= retry_cnt + RW'(1);
                     state     <= S_ISSUE;
                  end
               end else if (data_hit) begin
                  resp_valid_o[owner] <= 1'b1;
                  resp_data_o         <= dmem_resp_data_i;
                  state               <= S_IDLE;
               end else if (tmo_hit) begin
                  resp_valid_o[owner] <= 1'b1;
                  resp_error_o        <= 1'b1;
                  state               <= S_IDLE;
               end else if (tmo_cnt != '1) begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            S_DRAIN: begin
               if (nack_hit || data_hit || tmo_hit) begin
                  state <= S_IDLE;
               end else if (tmo_cnt != '1) begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Bench for dcache_req_arbiter: directed scenarios with literal expectations plus a
// transaction-level model compared against every DUT output each cycle.
module tb_dcache_req_arbiter;
   localparam int DW = 128, AW = 40, MAXR = 7, TMO = 255;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rstn;
   logic [1:0]         req_valid, req_ready;
   logic [1:0][4:0]    req_cmd, req_rd;
   logic [1:0][AW-1:0] req_addr;
   logic [1:0][3:0]    req_size;
   logic [1:0][DW-1:0] req_data;
   logic               kill;
   logic               dmem_req_valid, dmem_req_ready, dmem_req_kill;
   logic [4:0]         dmem_req_cmd;
   logic [AW-1:0]      dmem_req_addr;
   logic [3:0]         dmem_op_type;
   logic [DW-1:0]      dmem_req_data;
   logic [7:0]         dmem_req_tag;
   logic               dmem_resp_valid, dmem_resp_nack;
   logic [7:0]         dmem_resp_tag;
   logic [DW-1:0]      dmem_resp_data;
   logic [1:0]         resp_valid;
   logic               resp_error, busy;
   logic [DW-1:0]      resp_data;

   dcache_req_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_RETRY(MAXR), .TIMEOUT(TMO)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_cmd_i(req_cmd), .req_addr_i(req_addr), .req_size_i(req_size),
      .req_data_i(req_data), .req_rd_i(req_rd), .kill_i(kill),
      .dmem_req_valid_o(dmem_req_valid), .dmem_req_ready_i(dmem_req_ready),
      .dmem_req_cmd_o(dmem_req_cmd), .dmem_req_addr_o(dmem_req_addr),
      .dmem_op_type_o(dmem_op_type), .dmem_req_data_o(dmem_req_data),
      .dmem_req_tag_o(dmem_req_tag), .dmem_req_kill_o(dmem_req_kill),
      .dmem_resp_valid_i(dmem_resp_valid), .dmem_resp_nack_i(dmem_resp_nack),
      .dmem_resp_tag_i(dmem_resp_tag), .dmem_resp_data_i(dmem_resp_data),
      .resp_valid_o(resp_valid), .resp_error_o(resp_error),
      .resp_data_o(resp_data), .busy_o(busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Abstract model: phase of the single access (0 none, 1 offered, 2 in flight, 3 being drained).
   int            m_ph = 0, m_tries = 0, m_age = 0;
   bit            m_rr = 0, m_own = 0, m_init = 0, m_rerr = 0;
   logic [7:0]    m_tag = '0;
   logic [4:0]    m_cmd = '0;
   logic [AW-1:0] m_addr = '0;
   logic [3:0]    m_size = '0;
   logic [DW-1:0] m_wdata = '0, m_rdata = '0;
   logic [1:0]    m_rv = '0;

   logic [1:0]    s_ready, s_rv;
   logic          s_dvld, s_kill, s_rerr, s_busy;
   logic [7:0]    s_tag;
   logic [DW-1:0] s_rdata;

   task automatic finish_err();
      m_rv[m_own] = 1'b1;
      m_rerr      = 1'b1;
      m_ph        = 0;
   endtask

   task automatic tick();
      logic [1:0] e_ready;
      bit         gb, hit;
      @(negedge clk);
      s_ready = req_ready;   s_dvld = dmem_req_valid; s_tag  = dmem_req_tag;
      s_kill  = dmem_req_kill; s_rv = resp_valid;     s_rerr = resp_error;
      s_rdata = resp_data;   s_busy = busy;
      gb = (req_valid == 2'b11) ? m_rr : req_valid[1];
      e_ready = '0;
      if (rstn && m_ph == 0 && req_valid != 2'b00) e_ready[gb] = 1'b1;
      if (m_init) begin
         check("req_ready", req_ready, e_ready);
         check("dmem_req_valid", dmem_req_valid, m_ph == 1);
         check("dmem_req_tag", dmem_req_tag, m_tag);
         check("dmem_req_cmd", dmem_req_cmd, m_cmd);
         check("dmem_req_addr", dmem_req_addr, m_addr);
         check("dmem_op_type", dmem_op_type, m_size);
         check("dmem_req_data", dmem_req_data, m_wdata);
         check("dmem_req_kill", dmem_req_kill,
               rstn && kill && ((m_ph == 1 && dmem_req_ready) || m_ph == 2));
         check("resp_valid", resp_valid, m_rv);
         check("resp_error", resp_error, m_rerr);
         check("resp_data", resp_data, m_rdata);
         check("busy", busy, m_ph != 0);
      end
      hit  = (dmem_resp_tag == m_tag);
      m_rv = '0;
      m_rerr = 1'b0;
      if (!rstn) begin
         m_ph = 0; m_rr = 0; m_own = 0; m_tries = 0; m_age = 0;
         m_tag = '0; m_cmd = '0; m_addr = '0; m_size = '0; m_wdata = '0; m_rdata = '0;
         m_init = 1;
      end else if (m_ph == 0) begin
         if (req_valid != 2'b00) begin
            m_own = gb; m_rr = ~gb; m_tries = 0;
            m_tag = {1'b0, gb, req_rd[gb], 1'b0};
            m_cmd = req_cmd[gb]; m_addr = req_addr[gb];
            m_size = req_size[gb]; m_wdata = req_data[gb];
            m_ph = 1;
         end
      end else if (m_ph == 1) begin
         if (kill) m_ph = 0;
         else if (dmem_req_ready) begin m_ph = 2; m_age = 0; end
      end else if (m_ph == 2) begin
         if (kill) begin
            m_ph = (hit && (dmem_resp_valid || dmem_resp_nack)) ? 0 : 3;
            m_age = 0;
         end else if (hit && dmem_resp_nack) begin
            if (m_tries == MAXR) finish_err();
            else begin m_tries++; m_ph = 1; end
         end else if (hit && dmem_resp_valid) begin
            m_rv[m_own] = 1'b1; m_rdata = dmem_resp_data; m_ph = 0;
         end else if (m_age == TMO) finish_err();
         else m_age++;
      end else begin
         if (hit && (dmem_resp_valid || dmem_resp_nack)) m_ph = 0;
         else if (m_age == TMO) m_ph = 0;
         else m_age++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0; tick(); tick(); rstn = 1'b1;
   endtask

   task automatic accept(input logic [1:0] v);
      req_valid = v; tick(); req_valid = 2'b00;
   endtask

   task automatic issue();
      dmem_req_ready = 1'b1; tick(); dmem_req_ready = 1'b0;
   endtask

   task automatic resp(input bit nack, input logic [7:0] tag, input logic [DW-1:0] d);
      dmem_resp_valid = !nack; dmem_resp_nack = nack; dmem_resp_tag = tag; dmem_resp_data = d;
      tick();
      dmem_resp_valid = 1'b0; dmem_resp_nack = 1'b0; dmem_resp_tag = '0; dmem_resp_data = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] grants [3];
      logic [7:0] tg;
      int n;
      rstn = 1'b0; req_valid = '0; kill = 1'b0; dmem_req_ready = 1'b0;
      dmem_resp_valid = 1'b0; dmem_resp_nack = 1'b0; dmem_resp_tag = '0; dmem_resp_data = '0;
      req_cmd[0] = 5'd0; req_addr[0] = 40'h80001000; req_size[0] = 4'd3;
      req_data[0] = 128'h1111; req_rd[0] = 5'd5;
      req_cmd[1] = 5'd1; req_addr[1] = 40'h2000; req_size[1] = 4'd2;
      req_data[1] = 128'h2222; req_rd[1] = 5'd3;

      do_reset();
      tick();
      check("reset_dvld", s_dvld, 1'b0);
      check("reset_busy", s_busy, 1'b0);
      check("reset_rv", s_rv, 2'b00);
      check("reset_rdata", s_rdata, '0);

      // Single load
      accept(2'b01);
      check("load_ready", s_ready, 2'b01);
      tick();
      check("load_dvld", s_dvld, 1'b1);
      check("load_tag", s_tag, 8'h0A);
      issue();
      resp(1'b0, 8'h0A, 128'hDEAD);
      tick();
      check("load_rv", s_rv, 2'b01);
      check("load_rdata", s_rdata, 128'hDEAD);

      // Contention with both requesters held
      do_reset();
      req_valid = 2'b11;
      dmem_req_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick(); grants[k] = s_ready;
         tick(); tg = s_tag;
         if (k == 1) check("req1_tag", tg, 8'h46);
         resp(1'b0, tg, 128'(k + 16));
      end
      req_valid = 2'b00;
      dmem_req_ready = 1'b0;
      check("grant0", grants[0], 2'b01);
      check("grant1", grants[1], 2'b10);
      check("grant2", grants[2], 2'b01);

      // Two NACK replays then success
      accept(2'b01);
      issue();
      resp(1'b1, 8'h0A, '0);
      issue();
      check("replay1_dvld", s_dvld, 1'b1);
      check("replay1_tag", s_tag, 8'h0A);
      resp(1'b1, 8'h0A, '0);
      issue();
      check("replay2_tag", s_tag, 8'h0A);
      resp(1'b0, 8'h0A, 128'hCAFE);
      tick();
      check("replay_rv", s_rv, 2'b01);
      check("replay_err", s_rerr, 1'b0);
      check("replay_rdata", s_rdata, 128'hCAFE);

      // Retry exhaustion
      accept(2'b01);
      for (int k = 0; k < MAXR + 1; k++) begin
         issue();
         resp(1'b1, 8'h0A, '0);
      end
      tick();
      check("exhaust_rv", s_rv, 2'b01);
      check("exhaust_err", s_rerr, 1'b1);

      // Kill in WAIT, later response swallowed
      accept(2'b01);
      issue();
      kill = 1'b1; tick(); kill = 1'b0;
      check("killw_kill", s_kill, 1'b1);
      tick();
      check("killw_kill_off", s_kill, 1'b0);
      check("killw_busy", s_busy, 1'b1);
      resp(1'b0, 8'h0A, 128'hBEEF);
      check("killw_busy_drain", s_busy, 1'b1);
      tick();
      check("killw_rv", s_rv, 2'b00);
      check("killw_idle", s_busy, 1'b0);

      // Timeout on requester 1 with a foreign-tag response in the middle
      accept(2'b10);
      issue();
      n = 0;
      for (int k = 0; k < 400 && s_rv == 2'b00; k++) begin
         if (k == 100) begin
            dmem_resp_valid = 1'b1; dmem_resp_tag = 8'h12; dmem_resp_data = 128'h99;
         end else begin
            dmem_resp_valid = 1'b0; dmem_resp_tag = '0; dmem_resp_data = '0;
         end
         tick();
         n = k + 1;
      end
      check("tmo_cycles", n, 257);
      check("tmo_rv", s_rv, 2'b10);
      check("tmo_err", s_rerr, 1'b1);

      // Kill in ISSUE together with ready
      accept(2'b01);
      dmem_req_ready = 1'b1; kill = 1'b1; tick(); dmem_req_ready = 1'b0; kill = 1'b0;
      check("killi_kill", s_kill, 1'b1);
      tick();
      check("killi_idle", s_busy, 1'b0);
      check("killi_rv", s_rv, 2'b00);

      // Reset during ISSUE
      accept(2'b01);
      rstn = 1'b0; tick(); rstn = 1'b1;
      check("rsti_dvld_before", s_dvld, 1'b1);
      tick();
      check("rsti_dvld", s_dvld, 1'b0);
      check("rsti_busy", s_busy, 1'b0);
      check("rsti_tag", s_tag, 8'h00);
      check("rsti_rdata", s_rdata, '0);
      req_valid = 2'b11; tick(); req_valid = 2'b00;
      check("rsti_rr", s_ready, 2'b01);
      kill = 1'b1; tick(); kill = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/dcache_req_arbiter.md
Name: dcache_req_arbiter

Overview:
- Shares the single data-cache request port between two requesters: port 0 is the load/store pipeline and port 1 is the page-table walker / store buffer drain.
- Sits in front of dcache_interface's cache-facing signals. Accepts one request at a time, holds it until the cache accepts it, and tracks the single outstanding access by tag.
- Replays NACKed accesses up to a limit and routes the response back to the owning requester.
- Handles kill, retry exhaustion and response timeout.

Parameters:
DATA_W, 128, width of store data and load response data
ADDR_W, 40, physical/virtual address width
MAX_RETRY, 7, NACK replays allowed before reporting an error
TIMEOUT, 255, cycles to wait in WAIT before reporting an error

Ports:
clk_i  in  1  clock
rstn_i  in  1  synchronous active-low reset
req_valid_i  in  2  request valid, bit n = requester n
req_ready_o  out  2  one-cycle accept pulse per requester
req_cmd_i  in  2x5  dcache command per requester
req_addr_i  in  2xADDR_W  address per requester
req_size_i  in  2x4  access granularity per requester
req_data_i  in  2xDATA_W  store data per requester
req_rd_i  in  2x5  destination register per requester
kill_i  in  1  abort the current access
dmem_req_valid_o  out  1  request to dcache
dmem_req_ready_i  in  1  dcache accepts request
dmem_req_cmd_o  out  5  latched command
dmem_req_addr_o  out  ADDR_W  latched address
dmem_op_type_o  out  4  latched size
dmem_req_data_o  out  DATA_W  latched store data
dmem_req_tag_o  out  8  issued tag
dmem_req_kill_o  out  1  kill of the in-flight access
dmem_resp_valid_i  in  1  dcache response valid
dmem_resp_nack_i  in  1  dcache NACK
dmem_resp_tag_i  in  8  response tag
dmem_resp_data_i  in  DATA_W  response data
resp_valid_o  out  2  one-cycle completion pulse per requester
resp_error_o  out  1  qualifies resp_valid_o: retry exhausted or timeout
resp_data_o  out  DATA_W  response data, shared by both requesters
busy_o  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk_i. rstn_i is synchronous and active-low.
- Reset state:
  - state=IDLE, rr=0.
  - Retry and timeout counters cleared; all latches cleared.
  - All outputs 0 (resp_data_o = 0).
  - Reset mid-access drops the access silently: no dmem_req_kill_o, no response.
- Tag: {1'b0, owner, rd[4:0], 1'b0}, latched at accept.
- A response or NACK matches only when dmem_resp_tag_i equals the issued tag. Non-matching responses are ignored in every state.
- IDLE:
  - If exactly one req_valid_i bit is set, grant it. If both are set, grant requester rr.
  - The grant drives req_ready_o[g]=1 combinationally in the same cycle, latches g's fields, sets rr=~g, and moves to ISSUE.
  - kill_i has no effect in IDLE.
- ISSUE:
  - dmem_req_valid_o=1 with the latched fields, held stable until dmem_req_ready_i.
  - On ready: move to WAIT and clear the timeout counter.
  - kill_i (with or without ready): move to IDLE, assert dmem_req_kill_o=1 only if ready was also high, no response.
  - Accept at cycle N implies first dmem_req_valid_o at cycle N+1.
- WAIT, in priority order (first match wins):
  1. kill_i: dmem_req_kill_o=1 this cycle and move to DRAIN. A same-cycle matching response is discarded and the block moves to IDLE instead.
  2. Matching dmem_resp_nack_i:
     - retry_cnt==MAX_RETRY: resp_valid_o[owner]=1 with resp_error_o=1 next cycle, then IDLE.
     - Otherwise: retry_cnt+1 and move to ISSUE (replay with the same tag).
  3. Matching dmem_resp_valid_i: register the data; resp_valid_o[owner]=1 and resp_data_o=data the next cycle; move to IDLE.
  4. Timeout counter reaches TIMEOUT: error response as in the retry-exhausted case, then IDLE.
  - NACK takes precedence over timeout when both occur in the same cycle.
- DRAIN: wait for a matching response or NACK, discard it, move to IDLE. The timeout counter also returns DRAIN to IDLE, silently.
- Response outputs: resp_valid_o is a one-cycle registered pulse. resp_data_o holds its value until the next response.
- A new request may be accepted in the same cycle resp_valid_o is high.
- Counters:
  - retry_cnt is clog2(MAX_RETRY+1) bits and is cleared on every accept.
  - The timeout counter is clog2(TIMEOUT+1) bits, saturates, and is cleared on entry to WAIT or DRAIN.

Test Plan:
- Single load: req_valid_i=01, cmd=0, rd=5, addr=0x80001000.
  - Expect req_ready_o=01 at N, dmem_req_valid_o at N+1 with tag=0x0A.
  - Drive ready, then resp tag 0x0A with data 0xDEAD → resp_valid_o=01 with resp_data_o=0xDEAD.
- Contention: req_valid_i=11 held after reset → grants alternate 0,1,0.
  - Requester 1 with rd=3 gets tag 0x46.
- NACK replay:
  - Two matching NACKs → two re-issues with an identical tag; then valid → normal response.
  - MAX_RETRY+1 NACKs → resp_error_o=1 with resp_valid_o=01.
- Kill in WAIT: kill_i → dmem_req_kill_o=1 for one cycle.
  - A later matching response is swallowed with resp_valid_o=0; busy_o drops the cycle after.
- Timeout: no response for 255 cycles after ready → error pulse on the owner; a foreign-tag response at cycle 100 is ignored.
- Reset asserted in ISSUE → next cycle all outputs 0, state IDLE, rr=0.
